// File: rtl/usb_line_state.sv
// USB full-speed line-state front end: synchronises D+/D-, deglitches the pair,
// and derives end-of-packet, suspend and resume indications from the filtered state.
module usb_line_state #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 3,
  parameter int unsigned EOP_MAX        = 8,
  parameter int unsigned SUSPEND_CYCLES = 144000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       usb_p_raw,
  input  logic       usb_n_raw,
  output logic       usb_p_rx,
  output logic       usb_n_rx,
  output logic [1:0] line_state,
  output logic       eop,
  output logic       suspend,
  output logic       resume
);

  localparam int unsigned FILT_W = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned SE0_W  = $clog2(EOP_MAX + 2);
  localparam int unsigned SUSP_W = $clog2(SUSPEND_CYCLES + 1);

  localparam logic [1:0] LS_SE0 = 2'd0;
  localparam logic [1:0] LS_J   = 2'd1;
  localparam logic [1:0] LS_K   = 2'd2;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("usb_line_state: SYNC_STAGES must be 2..3");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filt
    $error("usb_line_state: FILTER_CYCLES must be 1..15");
  end

  logic [SYNC_STAGES-1:0] sync_p;
  logic [SYNC_STAGES-1:0] sync_n;
  logic [1:0]             pair_sync;
  logic [1:0]             pair_ahead;
  logic [FILT_W-1:0]      stable_cnt;
  logic [FILT_W-1:0]      stable_cnt_next;
  logic [1:0]             ls_next;
  logic [SE0_W-1:0]       se0_cnt;
  logic [SE0_W-1:0]       se0_cnt_next;
  logic [SUSP_W-1:0]      susp_cnt;
  logic [SUSP_W-1:0]      susp_cnt_next;
  logic                   eop_next;
  logic                   suspend_next;
  logic                   resume_next;

  // Per-line synchroniser chains, parked at J so reset never looks like SE0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p <= '1;
      sync_n <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], usb_p_raw};
      sync_n <= {sync_n[SYNC_STAGES-2:0], usb_n_raw};
    end
  end

  assign pair_sync  = {sync_n[SYNC_STAGES-1], sync_p[SYNC_STAGES-1]};
  // The stage feeding the output flop is compared so a held change is seen one edge earlier.
  assign pair_ahead = {sync_n[SYNC_STAGES-2], sync_p[SYNC_STAGES-2]};

  // Stability counter and filtered-state acceptance.
  always_comb begin
    stable_cnt_next = stable_cnt;
    ls_next         = line_state;
    if (pair_ahead != pair_sync) begin
      stable_cnt_next = '0;
    end else if (stable_cnt != FILT_W'(FILTER_CYCLES)) begin
      stable_cnt_next = stable_cnt + FILT_W'(1);
    end
    if (stable_cnt_next == FILT_W'(FILTER_CYCLES) && pair_sync != line_state) begin
      ls_next = pair_sync;
    end
  end

  // Run-length counters and the eop/suspend/resume decisions.
  always_comb begin
    se0_cnt_next  = '0;
    susp_cnt_next = '0;
    if (line_state == LS_SE0) begin
      se0_cnt_next = (se0_cnt == SE0_W'(EOP_MAX + 1)) ? se0_cnt : se0_cnt + SE0_W'(1);
    end
    if (line_state == LS_J) begin
      susp_cnt_next = (susp_cnt == SUSP_W'(SUSPEND_CYCLES)) ? susp_cnt
                                                            : susp_cnt + SUSP_W'(1);
    end
    eop_next     = (line_state == LS_J) && (se0_cnt != '0) &&
                   (se0_cnt <= SE0_W'(EOP_MAX));
    suspend_next = (ls_next == LS_J) &&
                   (suspend || (susp_cnt_next == SUSP_W'(SUSPEND_CYCLES)));
    resume_next  = suspend && (ls_next == LS_K);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_cnt <= '0;
      line_state <= LS_J;
      se0_cnt    <= '0;
      susp_cnt   <= '0;
      eop        <= 1'b0;
      suspend    <= 1'b0;
      resume     <= 1'b0;
    end else begin
      stable_cnt <= stable_cnt_next;
      line_state <= ls_next;
      se0_cnt    <= se0_cnt_next;
      susp_cnt   <= susp_cnt_next;
      eop        <= eop_next;
      suspend    <= suspend_next;
      resume     <= resume_next;
    end
  end

  assign usb_p_rx = line_state[0];
  assign usb_n_rx = line_state[1];

endmodule

// File: tb/tb_usb_line_state.sv
// Bench for usb_line_state: directed literal checks plus random line traffic
// compared every cycle against a sample-window reference model.
module tb_usb_line_state;

  localparam int unsigned S   = 2;
  localparam int unsigned F   = 3;
  localparam int unsigned EM  = 8;
  localparam int unsigned SUS = 300;

  localparam logic [1:0] SE0 = 2'd0;
  localparam logic [1:0] J   = 2'd1;
  localparam logic [1:0] K   = 2'd2;
  localparam logic [1:0] SE1 = 2'd3;

  logic       clk;
  logic       reset_n;
  logic       usb_p_raw;
  logic       usb_n_raw;
  logic       usb_p_rx;
  logic       usb_n_rx;
  logic [1:0] line_state;
  logic       eop;
  logic       suspend;
  logic       resume;

  int checks = 0;
  int errors = 0;

  usb_line_state #(
    .SYNC_STAGES(S), .FILTER_CYCLES(F), .EOP_MAX(EM), .SUSPEND_CYCLES(SUS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .usb_p_raw(usb_p_raw), .usb_n_raw(usb_n_raw),
    .usb_p_rx(usb_p_rx), .usb_n_rx(usb_n_rx), .line_state(line_state),
    .eop(eop), .suspend(suspend), .resume(resume)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the filtered state takes a raw value once F+1 consecutive raw
  // samples agree, the newest of them being S-1 samples old.
  logic [1:0] m_hist[$];
  logic [1:0] m_ls = J;
  logic [1:0] m_nxt;
  bit         m_same;
  bit         m_eop = 0;
  bit         m_res = 0;
  bit         m_sus = 0;
  int         m_se0_run = 0;
  int         m_j_run = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_hist = {};
      for (int i = 0; i < S + F; i++) m_hist.push_back(J);
      m_ls = J; m_eop = 0; m_res = 0; m_sus = 0; m_se0_run = 0; m_j_run = 0;
    end else begin
      m_hist.push_back({usb_n_raw, usb_p_raw});
      void'(m_hist.pop_front());
      m_same = 1;
      for (int i = 1; i <= F; i++) if (m_hist[i] != m_hist[0]) m_same = 0;
      m_nxt     = m_same ? m_hist[0] : m_ls;
      m_eop     = (m_ls == J) && (m_se0_run >= 1) && (m_se0_run <= EM);
      m_se0_run = (m_ls == SE0) ? m_se0_run + 1 : 0;
      m_j_run   = (m_ls == J) ? m_j_run + 1 : 0;
      m_res     = m_sus && (m_nxt == K);
      m_sus     = (m_nxt == J) && (m_j_run >= SUS);
      m_ls      = m_nxt;
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({usb_n_rx, usb_p_rx} !== m_ls || line_state !== m_ls || eop !== m_eop ||
        resume !== m_res || suspend !== m_sus) begin
      errors++;
      if (errors <= 20)
        $display("FAIL model_cmp t=%0t act ls=%0d p=%b n=%b eop=%b res=%b sus=%b exp ls=%0d eop=%b res=%b sus=%b",
                 $time, line_state, usb_p_rx, usb_n_rx, eop, resume, suspend,
                 m_ls, m_eop, m_res, m_sus);
    end
  end

  // Event monitor sampled just after each active edge.
  int         mon_eop = 0, mon_res = 0, mon_chg = 0, mon_cyc = 0;
  int         mon_j_at = 0, mon_eop_at = 0;
  logic [1:0] mon_prev = J;

  always @(posedge clk) begin
    #1;
    mon_cyc++;
    mon_eop += int'(eop);
    mon_res += int'(resume);
    if (line_state != mon_prev) mon_chg++;
    if (line_state == J && mon_prev != J) mon_j_at = mon_cyc;
    if (eop) mon_eop_at = mon_cyc;
    mon_prev = line_state;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic hold(input logic [1:0] s, input int cyc);
    @(negedge clk);
    usb_p_raw = s[0];
    usb_n_raw = s[1];
    repeat (cyc - 1) @(negedge clk);
  endtask

  task automatic clear_mon();
    mon_eop = 0; mon_res = 0; mon_chg = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_p"}, int'(usb_p_rx), 1);
    check({tag, "_n"}, int'(usb_n_rx), 0);
    check({tag, "_ls"}, int'(line_state), 1);
    check({tag, "_eop"}, int'(eop), 0);
    check({tag, "_sus"}, int'(suspend), 0);
    check({tag, "_res"}, int'(resume), 0);
  endtask

  int         n, c, kind;
  logic [1:0] st;

  initial begin
    reset_n = 1'b0; usb_p_raw = 1'b1; usb_n_raw = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk); #2 reset_n = 1'b1;

    // J to K held: filtered change exactly S+F edges after the first sample.
    hold(J, 12);
    @(negedge clk); usb_p_raw = 1'b0; usb_n_raw = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check("j2k_ls", int'(line_state), (k == 5) ? 2 : 1);
    end
    check("j2k_p", int'(usb_p_rx), 0);
    hold(K, 6);

    // Two-cycle K glitch inside J changes nothing.
    hold(J, 12); clear_mon();
    hold(K, 2); hold(J, 15);
    check("glitch_chg", mon_chg, 0);
    check("glitch_eop", mon_eop, 0);

    // EOP length boundaries.
    hold(J, 12); clear_mon(); hold(SE0, 6); hold(J, 15);
    check("eop6_cnt", mon_eop, 1);
    check("eop6_lag", mon_eop_at - mon_j_at, 1);
    hold(J, 12); clear_mon(); hold(SE0, 9); hold(J, 15);
    check("eop9_cnt", mon_eop, 0);
    hold(J, 12); clear_mon(); hold(SE0, 8); hold(J, 15);
    check("eop8_cnt", mon_eop, 1);
    hold(J, 12); clear_mon(); hold(SE0, 5); hold(K, 10); hold(J, 15);
    check("eop_se0k_cnt", mon_eop, 0);

    // Suspend onset, then resume on K.
    hold(K, 10);
    @(negedge clk); usb_p_raw = 1'b1; usb_n_raw = 1'b0;
    n = 0;
    while (line_state != J && n < 50) begin @(posedge clk); #1; n++; end
    check("wait_j", int'(n < 50), 1);
    c = 0;
    while (!suspend && c < SUS + 20) begin @(posedge clk); #1; c++; end
    check("susp_delay", c, SUS);
    repeat (10) @(posedge clk);
    #1 check("susp_hold", int'(suspend), 1);
    @(negedge clk); usb_p_raw = 1'b0; usb_n_raw = 1'b1;
    n = 0;
    while (line_state != K && n < 50) begin @(posedge clk); #1; n++; end
    check("wait_k", int'(n < 50), 1);
    check("resume_pulse", int'(resume), 1);
    check("resume_sus", int'(suspend), 0);
    @(posedge clk); #1 check("resume_once", int'(resume), 0);

    // Suspend left via SE0: no resume; then reset in the middle of SE0.
    hold(J, SUS + 30);
    check("susp_again", int'(suspend), 1);
    clear_mon(); hold(SE0, 20);
    check("se0_nores", mon_res, 0);
    check("se0_nosus", int'(suspend), 0);
    @(negedge clk); #2 reset_n = 1'b0;
    #1 check_reset_outputs("midse0_rst");
    @(negedge clk); #2 reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check("post_rst_ls", int'(line_state), (k == 5) ? 0 : 1);
    end

    // Random line traffic, occasionally long enough to suspend.
    repeat (300) begin
      kind = int'($urandom_range(0, 19));
      if (kind == 0) begin
        hold(J, SUS + int'($urandom_range(0, 40)));
        hold(($urandom_range(0, 1) == 0) ? K : SE0, int'($urandom_range(1, 8)));
      end else begin
        c = int'($urandom_range(0, 9));
        st = (c < 4) ? J : (c < 6) ? K : (c < 9) ? SE0 : SE1;
        hold(st, int'($urandom_range(1, 12)));
      end
    end

    hold(J, 10);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
